// File: rtl/ncejdtm200_dmi_bridge.sv
// DMI (JTAG TAP) to AHB-Lite single-word master bridge with sticky op-status.
// Define NCEJDTM200_DMI_TIMEOUT_EN to add the data-phase timeout and DRAIN state.
module ncejdtm200_dmi_bridge #(
  parameter int DMI_ADDR_BITS = 7,
  parameter int TIMEOUT_BITS  = 8
) (
  input  logic                      dmi_hclk,
  input  logic                      dmi_hresetn,
  input  logic                      tap_dmi_req,
  input  logic [DMI_ADDR_BITS+33:0] tap_dmi_data,
  input  logic                      tap_dmi_reset,
  output logic                      dmi_tap_ack,
  output logic [31:0]               dmi_tap_hrdata,
  output logic [1:0]                dmi_tap_resp,
  input  logic                      dmi_hready,
  input  logic                      dmi_hresp,
  input  logic [31:0]               dmi_hrdata,
  output logic [31:0]               dmi_haddr,
  output logic [1:0]                dmi_htrans,
  output logic                      dmi_hwrite,
  output logic [2:0]                dmi_hsize,
  output logic [2:0]                dmi_hburst,
  output logic [3:0]                dmi_hprot,
  output logic [31:0]               dmi_hwdata,
  output logic                      dmi_hsel
);

  localparam int REQ_W = DMI_ADDR_BITS + 34;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_RSV   = 2'b11;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [1:0] RESP_OK     = 2'b00;
  localparam logic [1:0] RESP_FAILED = 2'b10;
`ifdef NCEJDTM200_DMI_TIMEOUT_EN
  localparam logic [1:0] RESP_BUSY   = 2'b11;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_ACK,
    ST_DRAIN
  } state_e;

  if (DMI_ADDR_BITS < 1 || DMI_ADDR_BITS > 30) begin : g_addr_bits_check
    $error("DMI_ADDR_BITS must be in 1..30");
  end
  if (TIMEOUT_BITS < 2) begin : g_timeout_bits_check
    $error("TIMEOUT_BITS must be at least 2");
  end

  state_e             state_q, state_d;
  logic [1:0]         htrans_q, htrans_d;
  logic               ack_q, ack_d;
  logic [31:0]        hrdata_q, hrdata_d;
  logic [1:0]         resp_q, resp_d;
  logic [1:0]         sticky_q, sticky_d;
  logic [REQ_W-1:0]   req_q, req_d;

  logic [1:0]               new_op;
  logic [1:0]               lat_op;
  logic [DMI_ADDR_BITS-1:0] lat_addr;
  logic [31:0]              lat_data;

  assign new_op   = tap_dmi_data[1:0];
  assign lat_op   = req_q[1:0];
  assign lat_data = req_q[33:2];
  assign lat_addr = req_q[REQ_W-1:34];

`ifdef NCEJDTM200_DMI_TIMEOUT_EN
  logic [TIMEOUT_BITS-1:0] tmo_q, tmo_d;
  logic [TIMEOUT_BITS-1:0] tmo_inc;
  assign tmo_inc = tmo_q + TIMEOUT_BITS'(1);
`endif

  always_comb begin
    state_d  = state_q;
    htrans_d = htrans_q;
    ack_d    = ack_q;
    hrdata_d = hrdata_q;
    resp_d   = resp_q;
    req_d    = req_q;
    // dmireset clears sticky unless a new error is recorded this same cycle
    sticky_d = tap_dmi_reset ? 2'b00 : sticky_q;
`ifdef NCEJDTM200_DMI_TIMEOUT_EN
    tmo_d    = '0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (tap_dmi_req && !ack_q && dmi_hready) begin
          if (new_op == OP_RSV) begin
            sticky_d = RESP_FAILED;
            resp_d   = RESP_FAILED;
            ack_d    = 1'b1;
            state_d  = ST_ACK;
          end else if (new_op == OP_NOP || sticky_q != 2'b00) begin
            resp_d  = sticky_q;
            ack_d   = 1'b1;
            state_d = ST_ACK;
          end else begin
            req_d    = tap_dmi_data;
            htrans_d = HTRANS_NONSEQ;
            state_d  = ST_ADDR;
          end
        end
      end

      ST_ADDR: begin
        if (dmi_hready) begin
          htrans_d = HTRANS_IDLE;
          state_d  = ST_DATA;
        end
      end

      ST_DATA: begin
        if (dmi_hready) begin
          if (dmi_hresp) begin
            sticky_d = RESP_FAILED;
            resp_d   = RESP_FAILED;
          end else begin
            resp_d = RESP_OK;
            if (lat_op == OP_READ) begin
              hrdata_d = dmi_hrdata;
            end
          end
          // a request withdrawn mid-transfer finishes on the bus silently
          if (tap_dmi_req) begin
            ack_d   = 1'b1;
            state_d = ST_ACK;
          end else begin
            state_d = ST_IDLE;
          end
        end
`ifdef NCEJDTM200_DMI_TIMEOUT_EN
        else begin
          tmo_d = tmo_inc;
          if (&tmo_inc) begin
            tmo_d    = '0;
            sticky_d = RESP_BUSY;
            resp_d   = RESP_BUSY;
            ack_d    = tap_dmi_req;
            state_d  = ST_DRAIN;
          end
        end
`endif
      end

      ST_ACK: begin
        if (!tap_dmi_req) begin
          ack_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end

`ifdef NCEJDTM200_DMI_TIMEOUT_EN
      // the abandoned data phase must still retire before the bus is reused
      ST_DRAIN: begin
        if (dmi_hready) begin
          if (ack_q && tap_dmi_req) begin
            state_d = ST_ACK;
          end else begin
            ack_d   = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
`endif

      default: begin
        state_d  = ST_IDLE;
        htrans_d = HTRANS_IDLE;
        ack_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge dmi_hclk or negedge dmi_hresetn) begin
    if (!dmi_hresetn) begin
      state_q  <= ST_IDLE;
      htrans_q <= HTRANS_IDLE;
      ack_q    <= 1'b0;
      hrdata_q <= '0;
      resp_q   <= '0;
      sticky_q <= '0;
      req_q    <= '0;
`ifdef NCEJDTM200_DMI_TIMEOUT_EN
      tmo_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      htrans_q <= htrans_d;
      ack_q    <= ack_d;
      hrdata_q <= hrdata_d;
      resp_q   <= resp_d;
      sticky_q <= sticky_d;
      req_q    <= req_d;
`ifdef NCEJDTM200_DMI_TIMEOUT_EN
      tmo_q    <= tmo_d;
`endif
    end
  end

  assign dmi_tap_ack    = ack_q;
  assign dmi_tap_hrdata = hrdata_q;
  assign dmi_tap_resp   = resp_q;

  assign dmi_haddr  = 32'({lat_addr, 2'b00});
  assign dmi_htrans = htrans_q;
  assign dmi_hwrite = (lat_op == OP_WRITE);
  assign dmi_hwdata = lat_data;
  assign dmi_hsize  = 3'b010;
  assign dmi_hburst = 3'b000;
  assign dmi_hprot  = 4'b0001;
  assign dmi_hsel   = 1'b1;

endmodule
